// File: rtl/uart_monitor_seq.sv
// Frames NCH signed channel values as text for a UART: per channel one itoa conversion, 6 chars, SEP between, CR LF at end.
// Byte output holds steady under i_tx_ready=0; a silent converter is replaced by " ERR  " after TMO cycles.
module uart_monitor_seq #(
  parameter int          NCH = 4,
  parameter logic [7:0]  SEP = 8'h20,
  parameter int          TMO = 31
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_trig,
  input  logic [NCH-1:0][15:0]   i_val,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_itoa_en,
  output logic signed [15:0]     o_itoa_val,
  input  logic                   i_itoa_en,
  input  logic [5:0][7:0]        i_itoa_str,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_ready
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_SEPB  = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;

  // element 0 is the leftmost character
  localparam logic [5:0][7:0] ERR_TXT = {8'h20, 8'h20, 8'h52, 8'h52, 8'h45, 8'h20};

  logic [2:0]           state;
  logic [NCH-1:0][15:0] snap;
  logic [CW-1:0]        ch;
  logic [7:0]           cnt;
  logic [2:0]           k;
  logic [5:0][7:0]      txt_buf;
  logic                 done_q;

  wire last_ch = (ch == CW'(NCH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      snap    <= '0;
      ch      <= '0;
      cnt     <= '0;
      k       <= '0;
      txt_buf <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_trig) begin
            snap  <= i_val;
            ch    <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_itoa_en) begin
            txt_buf <= i_itoa_str;
            k       <= '0;
            state   <= S_SEND;
          end else if (cnt == 8'(TMO)) begin
            txt_buf <= ERR_TXT;
            k       <= '0;
            state   <= S_SEND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SEND: begin
          if (i_tx_ready) begin
            if (k == 3'd5) state <= last_ch ? S_CR : S_SEPB;
            else           k     <= k + 3'd1;
          end
        end
        S_SEPB: begin
          if (i_tx_ready) begin
            ch    <= ch + CW'(1);
            state <= S_START;
          end
        end
        S_CR: begin
          if (i_tx_ready) state <= S_LF;
        end
        S_LF: begin
          if (i_tx_ready) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // outputs decode from state only, so data cannot move while a byte is stalled
  always_comb begin
    o_busy     = (state != S_IDLE);
    o_done     = done_q;
    o_itoa_en  = (state == S_START);
    o_itoa_val = '0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state)
      S_START: o_itoa_val = snap[ch];
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = txt_buf[k];
      end
      S_SEPB: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SEP;
      end
      S_CR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h0D;
      end
      S_LF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h0A;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_monitor_seq.sv
// Bench for uart_monitor_seq (NCH=2): text frames checked against a decimal-formatting reference model.
module tb_uart_monitor_seq;

  localparam int NCH_TB = 2;
  localparam int TMO_TB = 31;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  i_trig;
  logic [NCH_TB-1:0][15:0] i_val;
  logic                  o_busy, o_done, o_itoa_en;
  logic signed [15:0]    o_itoa_val;
  logic                  i_itoa_en;
  logic [5:0][7:0]       i_itoa_str;
  logic                  o_tx_valid;
  logic [7:0]            o_tx_data;
  logic                  i_tx_ready;

  uart_monitor_seq #(.NCH(NCH_TB), .SEP(8'h20), .TMO(TMO_TB)) dut (
    .clk(clk), .rstn(rstn), .i_trig(i_trig), .i_val(i_val),
    .o_busy(o_busy), .o_done(o_done), .o_itoa_en(o_itoa_en), .o_itoa_val(o_itoa_val),
    .i_itoa_en(i_itoa_en), .i_itoa_str(i_itoa_str),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int conv_mode = 0;   // 0 answers quickly, 1 never answers, 2 answers too late
  int rdy_mode  = 0;   // 0 always ready, 1 ready one cycle in three, 2 random
  int done_cnt = 0, en_cnt = 0, stall_err = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Right-justified 6-character decimal text, element 0 leftmost.
  function automatic logic [5:0][7:0] itoa6(input int v);
    logic [5:0][7:0] s;
    int a, p;
    for (int i = 0; i < 6; i++) s[i] = 8'h20;
    a = (v < 0) ? -v : v;
    p = 5;
    do begin
      s[p] = 8'(48 + a % 10);
      a = a / 10;
      p--;
    end while (a != 0);
    if (v < 0) s[p] = 8'h2D;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Byte monitor: a byte presented at the negedge with ready high transfers at the next posedge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (prev_stall && o_tx_valid && (o_tx_data !== prev_data)) stall_err++;
      if (o_done) done_cnt++;
      if (o_itoa_en) en_cnt++;
    end
    prev_stall = rstn && o_tx_valid && !i_tx_ready;
    prev_data  = o_tx_data;
  end

  // Ready driver.
  initial begin
    int c;
    c = 0;
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      c++;
      case (rdy_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (c % 3 == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Converter model.
  initial begin
    logic signed [15:0] cv;
    int d;
    i_itoa_en  = 1'b0;
    i_itoa_str = '0;
    forever begin
      @(negedge clk);
      if (rstn && o_itoa_en && conv_mode != 1) begin
        cv = o_itoa_val;
        d  = (conv_mode == 2) ? TMO_TB + 4 : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1;
        i_itoa_en  = 1'b1;
        i_itoa_str = (conv_mode == 2) ? itoa6(999999) : itoa6(int'(cv));
        @(posedge clk); #1;
        i_itoa_en  = 1'b0;
      end
    end
  end

  task automatic run_frame(input logic [15:0] v0, input logic [15:0] v1,
                           input int cmode, input int rmode, input bit disturb);
    logic [5:0][7:0] s;
    int n, d0, e0, s0;
    exp_q.delete();
    got.delete();
    conv_mode = cmode;
    rdy_mode  = rmode;
    for (int c = 0; c < NCH_TB; c++) begin
      s = (cmode == 0) ? itoa6(int'($signed((c == 0) ? v0 : v1)))
                       : {8'h20, 8'h20, 8'h52, 8'h52, 8'h45, 8'h20};
      for (int i = 0; i < 6; i++) exp_q.push_back(s[i]);
      if (c < NCH_TB - 1) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    d0 = done_cnt; e0 = en_cnt; s0 = stall_err;
    i_val  = {v1, v0};
    i_trig = 1'b1;
    @(posedge clk); #1;
    i_trig = 1'b0;
    chk("busy_after_trig", 64'(o_busy), 64'd1);
    if (disturb) begin
      repeat (6) @(posedge clk);
      #1;
      i_val  = ~i_val;
      i_trig = 1'b1;
      @(posedge clk); #1;
      i_trig = 1'b0;
    end
    n = 0;
    while (!o_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(o_done), 64'd1);
    chk("busy_at_done", 64'(o_busy), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(o_done), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("frame_len", 64'(got.size()), 64'(7 * NCH_TB + 1));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(exp_q[i]));
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("itoa_starts", 64'(en_cnt - e0), 64'(NCH_TB));
    chk("stall_stable", 64'(stall_err - s0), 64'd0);
  endtask

  initial begin
    int n;
    rstn   = 1'b0;
    i_trig = 1'b0;
    i_val  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_busy, o_done, o_itoa_en, o_tx_valid, o_itoa_val, o_tx_data}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed: -123, 456 with ready held high
    run_frame(16'hFF85, 16'd456, 0, 0, 1'b0);
    // extreme negative value under 1-of-3 ready stalls
    run_frame(16'h8000, 16'd32767, 0, 1, 1'b0);
    // converter silent: both fields replaced by " ERR  "
    run_frame(16'd11, 16'd22, 1, 0, 1'b0);
    // converter answers only after timeout, during SEND: ignored
    run_frame(16'd33, 16'd44, 2, 1, 1'b0);
    // retrigger and input change mid-frame
    run_frame(16'd0, 16'hFFFF, 0, 2, 1'b1);

    // reset while channel 0 byte 3 is on the line
    conv_mode = 0; rdy_mode = 0;
    got.delete();
    i_val  = {16'd7, 16'hFFFB};
    i_trig = 1'b1;
    @(posedge clk); #1;
    i_trig = 1'b0;
    n = 0;
    while (got.size() < 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_bytes", 64'(got.size()), 64'd3);
    chk("pre_reset_valid", 64'(o_tx_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("reset_midframe_outputs", {o_busy, o_done, o_itoa_en, o_tx_valid, o_itoa_val, o_tx_data}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("no_bytes_after_reset", 64'(got.size()), 64'd3);
    chk("idle_after_reset", 64'(o_busy), 64'd0);
    run_frame(16'hFFFB, 16'd7, 0, 0, 1'b0);

    // randomized frames
    for (int f = 0; f < 6; f++)
      run_frame(16'($urandom), 16'($urandom), 0, int'($urandom_range(0, 2)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_monitor_seq.md
UART_MONITOR_SEQ -- requirements
Module: uart_monitor_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored channels (legal 1..8).
REQ-002 SHALL have parameter SEP, default 8'h20, separator byte between channel fields.
REQ-003 SHALL have parameter TMO, default 31, cycles to wait for a conversion before error substitution (legal 16..255).
REQ-004 rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 i_trig  input  1  request one frame.
REQ-007 i_val  input  16 x NCH, signed  channel values, index 0 first.
REQ-008 o_busy  output  1  frame in progress.
REQ-009 o_done  output  1  one-cycle pulse on frame completion.
REQ-010 o_itoa_en  output  1  conversion start pulse to converter.
REQ-011 o_itoa_val  output  16, signed  value to convert.
REQ-012 i_itoa_en  input  1  one-cycle conversion-done pulse from converter.
REQ-013 i_itoa_str  input  8 x 6  converted text; element 0 is the leftmost character.
REQ-014 o_tx_valid  output  1  byte available to UART transmitter.
REQ-015 o_tx_data  output  8  byte to transmit.
REQ-016 i_tx_ready  input  1  transmitter accepts byte.

Function
REQ-017 States SHALL be IDLE, START, WAIT, SEND, SEPB, CR, LF.
REQ-018 IDLE with i_trig=1 SHALL snapshot all i_val, clear channel index, go START; o_busy high from next cycle until IDLE re-entered.
REQ-019 i_trig while not IDLE SHALL be ignored (no queuing); snapshot SHALL not change during a frame.
REQ-020 START SHALL drive o_itoa_en=1 for exactly one cycle with o_itoa_val=snapshot[index], then go WAIT with timeout counter cleared.
REQ-021 WAIT SHALL latch i_itoa_str into a 6-byte buffer on i_itoa_en=1 and go SEND with character index 0.
REQ-022 WAIT SHALL, if counter reaches TMO with no i_itoa_en, load buffer with " ERR  " (20 45 52 52 20 20) and go SEND.
REQ-023 i_itoa_en outside WAIT SHALL be ignored.
REQ-024 SEND SHALL present buffer[k] on o_tx_data with o_tx_valid=1, k=0..5 in order.
REQ-025 A byte SHALL transfer only on a rising edge with o_tx_valid=1 and i_tx_ready=1; o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-026 After byte 5 transfers: last channel -> CR; otherwise -> SEPB.
REQ-027 SEPB SHALL send SEP, then increment channel index and go START.
REQ-028 CR SHALL send 8'h0D, then LF SHALL send 8'h0A; on LF transfer go IDLE and pulse o_done one cycle.
REQ-029 o_tx_valid SHALL be 0 in IDLE, START, WAIT; may stay 1 back-to-back across consecutive bytes (no bubble required, none forbidden).
REQ-030 Frame length SHALL be 7*NCH+1 bytes.

Reset
REQ-031 rstn=0 SHALL immediately force IDLE; o_busy, o_done, o_itoa_en, o_tx_valid=0; o_itoa_val, o_tx_data=0; buffer, snapshot, counters cleared.
REQ-032 Reset mid-frame SHALL abandon the frame with no further bytes after release until a new i_trig.

Verification
REQ-033 NCH=2, vals -123,456, ready held 1, converter model -> bytes 20 20 2D 31 32 33 20 20 20 20 34 35 36 0D 0A, then o_done pulse.
REQ-034 NCH=1, val -32768, i_tx_ready toggling 1-of-3 cycles -> 2D 33 32 37 36 38 0D 0A; data stable whenever stalled.
REQ-035 Converter never answers, NCH=1 -> after TMO cycles in WAIT, bytes 20 45 52 52 20 20 0D 0A.
REQ-036 i_trig pulsed again mid-frame, i_val changed mid-frame -> exactly one frame, contents match values at first trigger.
REQ-037 rstn asserted during SEND byte 3 -> outputs zero same cycle; after release no bytes until i_trig; next frame complete and correct.
REQ-038 Late i_itoa_en pulse arriving in SEND -> ignored, buffer unchanged.
